// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state type and BCD constants for the stopwatch slice
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  localparam int BCD_W = 4;
  localparam int NUM_DIGITS = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/stopwatch_if.sv
// stopwatch_if: button pulses in, display word and status out
//   start_stop/clear/lap : 1-cycle button pulses (master drives)
//   digit                : {sec_tens, sec_ones, tenths, hundredths} BCD
//   running/overflow/lap_active : status flags (slave drives)
interface stopwatch_if;
  import stopwatch_pkg::*;
  logic start_stop;
  logic clear;
  logic lap;
  logic [NUM_DIGITS*BCD_W-1:0] digit;
  logic running;
  logic overflow;
  logic lap_active;
  modport master (output start_stop, clear, lap, input digit, running, overflow, lap_active);
  modport slave (input start_stop, clear, lap, output digit, running, overflow, lap_active);
endinterface

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// bcd_digit: one decimal digit counter 0..9 with carry, for a ripple chain
//   clk, rst_n : clock, sync active-low reset
//   clr        : sync clear to 0
//   inc_in     : increment request (carry from lower digit)
//   q, q_nx    : current value and value after this edge
//   carry_out  : increment wraps 9 -> 0
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc_in,
  output logic [BCD_W-1:0] q,
  output logic [BCD_W-1:0] q_nx,
  output logic             carry_out
);
  assign carry_out = inc_in && q == BCD_MAX;
  assign q_nx = clr ? '0 : carry_out ? '0 : inc_in ? q + 4'd1 : q;
  always_ff @(posedge clk)
    q <= !rst_n ? '0 : q_nx;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/clear stopwatch counting SS.cc in BCD at TICK_HZ
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   sw    : stopwatch_if.slave (buttons in; digit, running, overflow, lap_active out)
//   Optional macro LAP_HOLD_EN: lap pulse in RUN freezes/releases the displayed value.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input logic clk,
  input logic rst_n,
  stopwatch_if.slave sw
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW = DIV > 2 ? $clog2(DIV) : 1;
  localparam int CW = NUM_DIGITS * BCD_W;
  if (DIV < 2) begin : g_div_chk
    $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be >= 2");
  end
  state_t state, state_nx;
  logic [PW-1:0] pre;
  logic tick, running, overflow;
  logic [NUM_DIGITS:0] inc;
  logic [CW-1:0] count, count_nx, digit;
  assign tick = state == RUN && pre == PW'(DIV - 1);
  assign inc[0] = tick;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_digit u_dig (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (sw.clear),
      .inc_in    (inc[i]),
      .q         (count[i*BCD_W +: BCD_W]),
      .q_nx      (count_nx[i*BCD_W +: BCD_W]),
      .carry_out (inc[i+1])
    );
  end
  always_comb
    state_nx = sw.clear ? IDLE : sw.start_stop ? (state == RUN ? PAUSE : RUN) : state;
  // Prescaler only advances in RUN; PAUSE holds it so resume completes the partial tick.
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      pre <= '0;
      running <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      running <= state_nx == RUN;
      pre <= (sw.clear || state == IDLE || tick) ? '0 : state == RUN ? pre + 1'b1 : pre;
      overflow <= !sw.clear && (overflow || inc[NUM_DIGITS]);
    end
`ifdef LAP_HOLD_EN
  logic hold;
  logic [CW-1:0] lap_reg;
  // Capture the post-update count so the frozen value matches what the display would show next.
  always_ff @(posedge clk)
    if (!rst_n || sw.clear) begin
      hold <= 1'b0;
      lap_reg <= '0;
    end else if (sw.lap && state == RUN) begin
      hold <= !hold;
      lap_reg <= hold ? lap_reg : count_nx;
    end
  always_ff @(posedge clk)
    digit <= !rst_n ? '0 : hold ? lap_reg : count;
  assign sw.lap_active = hold;
`else
  always_ff @(posedge clk)
    digit <= !rst_n ? '0 : count;
  assign sw.lap_active = 1'b0;
`endif
  assign sw.digit = digit;
  assign sw.running = running;
  assign sw.overflow = overflow;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: two stopwatch instances (DIV=10 and DIV=2) driven by one stimulus, scoreboarded
module tb_stopwatch_ctrl;
`ifdef LAP_HOLD_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif
  localparam int DIVS [2] = '{10, 2};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [18:0] sbq0 [$];
  logic [18:0] sbq1 [$];
  int run_cyc [2];
  int st [2];
  bit hold [2];
  int lapv [2];
  logic [15:0] disp [2];
  always #5 clk = ~clk;
  stopwatch_if sw0 ();
  stopwatch_if sw1 ();
  stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100)) dut0 (.clk(clk), .rst_n(rst_n), .sw(sw0));
  stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(500)) dut1 (.clk(clk), .rst_n(rst_n), .sw(sw1));
  function automatic logic [15:0] bcd(input int v);
    bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction
  // Elapsed time is simply the number of clock edges spent in RUN since the last clear.
  task automatic model(input int d, input logic rn, ss, cl, lp);
    logic [15:0] nd;
    bit was_run;
    if (!rn) begin
      run_cyc[d] = 0; st[d] = 0; hold[d] = 0; lapv[d] = 0; disp[d] = '0;
    end else begin
      nd = hold[d] ? bcd(lapv[d]) : bcd((run_cyc[d] / DIVS[d]) % 10000);
      if (cl) begin
        st[d] = 0; run_cyc[d] = 0; hold[d] = 0;
      end else begin
        was_run = st[d] == 1;
        if (was_run) run_cyc[d]++;
        if (ss) st[d] = st[d] == 1 ? 2 : 1;
        if (LAP_EN && lp && was_run) begin
          hold[d] = !hold[d];
          if (hold[d]) lapv[d] = (run_cyc[d] / DIVS[d]) % 10000;
        end
      end
      disp[d] = nd;
    end
  endtask
  function automatic logic [18:0] expv(input int d);
    expv = {disp[d], st[d] == 1, run_cyc[d] / DIVS[d] >= 10000, hold[d]};
  endfunction
  task automatic step(input logic rn, ss, cl, lp);
    rst_n = rn;
    sw0.start_stop = ss; sw0.clear = cl; sw0.lap = lp;
    sw1.start_stop = ss; sw1.clear = cl; sw1.lap = lp;
    @(posedge clk);
    model(0, rn, ss, cl, lp);
    model(1, rn, ss, cl, lp);
    sbq0.push_back(expv(0));
    sbq1.push_back(expv(1));
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
  endtask
  always @(negedge clk) begin
    logic [18:0] e, g;
    if (sbq0.size() > 0) begin
      e = sbq0.pop_front();
      g = {sw0.digit, sw0.running, sw0.overflow, sw0.lap_active};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL div10 t=%0t {digit,run,ovf,lap} got=%h_%b%b%b exp=%h_%b%b%b", $time,
                 g[18:3], g[2], g[1], g[0], e[18:3], e[2], e[1], e[0]);
      end
    end
    if (sbq1.size() > 0) begin
      e = sbq1.pop_front();
      g = {sw1.digit, sw1.running, sw1.overflow, sw1.lap_active};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL div2 t=%0t {digit,run,ovf,lap} got=%h_%b%b%b exp=%h_%b%b%b", $time,
                 g[18:3], g[2], g[1], g[0], e[18:3], e[2], e[1], e[0]);
      end
    end
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not complete, got=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    sw0.start_stop = 0; sw0.clear = 0; sw0.lap = 0;
    sw1.start_stop = 0; sw1.clear = 0; sw1.lap = 0;
    repeat (3) step(0, 0, 0, 0);
    idle(3);
    step(1, 1, 0, 0);
    idle(1005);
    step(1, 1, 0, 0);
    idle(100);
    step(1, 1, 0, 0);
    idle(20);
    step(1, 0, 1, 0);
    step(1, 1, 0, 0);
    idle(37);
    step(1, 1, 1, 0);
    idle(5);
    step(1, 1, 0, 0);
    idle(1229);
    step(1, 0, 0, 1);
    idle(100);
    step(1, 1, 0, 0);
    idle(30);
    step(1, 0, 0, 1);
    step(1, 1, 0, 0);
    idle(169);
    step(1, 0, 0, 1);
    idle(20);
    for (int i = 0; i < 4000; i++)
      step(1, $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0, $urandom_range(0, 29) == 0);
    step(1, 0, 1, 0);
    step(1, 1, 0, 0);
    idle(20010);
    step(1, 0, 0, 1);
    idle(10);
    step(1, 0, 1, 0);
    idle(5);
    step(0, 0, 0, 0);
    idle(3);
    repeat (2) @(negedge clk);
    #1;
    if (sbq0.size() != 0 || sbq1.size() != 0) begin
      bad++;
      $display("FAIL drain: left=%0d/%0d required=0/0", sbq0.size(), sbq1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
